// File: rtl/lbm_coord_pkg.sv
// -----------------------------------------------------------------------------
// lbm_coord_pkg
// Shared definitions for the LBM coordinate sweeper:
//   - Avalon-MM register word addresses
//   - CTRL register bit positions (write view and read view)
//   - sweeper FSM state encoding
// -----------------------------------------------------------------------------
package lbm_coord_pkg;

    // Register word addresses
    localparam logic [2:0] ADDR_CTRL      = 3'd0;
    localparam logic [2:0] ADDR_X_MAX     = 3'd1;
    localparam logic [2:0] ADDR_Y_MAX     = 3'd2;
    localparam logic [2:0] ADDR_SWEEPS    = 3'd3;
    localparam logic [2:0] ADDR_SWEEP_CNT = 3'd4;

    // CTRL write bits
    localparam int CTRL_START_BIT  = 0;
    localparam int CTRL_ABORT_BIT  = 1;
    localparam int CTRL_IRQ_EN_BIT = 2;

    // CTRL read bits (irq_en shares bit 2 with the write view)
    localparam int CTRL_BUSY_BIT   = 0;
    localparam int CTRL_DONE_BIT   = 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/lbm_coord_counter.sv
// -----------------------------------------------------------------------------
// lbm_coord_counter
// Two-dimensional raster wrap counter, x fastest.
//
// Ports:
//   clk, reset_n      clock, asynchronous active-low reset
//   clear             force (0,0); has priority over advance
//   advance           step to the next coordinate
//   x_max, y_max      inclusive bounds
//   x, y              current coordinate
//   wrap              pulse: this advance steps past (x_max, y_max)
//   last              current coordinate equals (x_max, y_max)
// -----------------------------------------------------------------------------
module lbm_coord_counter
    import lbm_coord_pkg::*;
#(
    parameter int COORD_W = 27
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               clear,
    input  logic               advance,
    input  logic [COORD_W-1:0] x_max,
    input  logic [COORD_W-1:0] y_max,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               wrap,
    output logic               last
);

    logic [COORD_W-1:0] x_q, x_d;
    logic [COORD_W-1:0] y_q, y_d;
    logic               x_more;
    logic               y_more;

    assign x_more = (x_q < x_max);
    assign y_more = (y_q < y_max);

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (clear) begin
            x_d = '0;
            y_d = '0;
        end else if (advance) begin
            if (x_more) begin
                x_d = x_q + 1'b1;
            end else begin
                x_d = '0;
                y_d = y_more ? (y_q + 1'b1) : '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign x    = x_q;
    assign y    = y_q;
    assign wrap = advance && !clear && !x_more && !y_more;
    assign last = (x_q == x_max) && (y_q == y_max);

endmodule

// File: rtl/lbm_coord_sweeper.sv
// -----------------------------------------------------------------------------
// lbm_coord_sweeper
// Avalon-MM configured raster coordinate sequencer for the LBM update engine.
// Software programs X_MAX / Y_MAX / SWEEPS and writes start; the block then
// emits one (x, y) per valid/ready handshake and counts completed sweeps.
//
// Ports:
//   clk, reset_n                  clock, asynchronous active-low reset
//   address, chipselect,          Avalon-MM slave (zero wait state; readdata
//   write_n, writedata, readdata  is combinational from address)
//   coord_x, coord_y              current coordinate
//   coord_valid / coord_ready     handshake to the datapath
//   coord_last                    last coordinate of a sweep
//   busy                          sweep sequence in progress
//   irq                           done interrupt (only with LBM_COORD_IRQ_EN)
//
// Build option: LBM_COORD_IRQ_EN adds the irq port and the CTRL.irq_en bit.
// -----------------------------------------------------------------------------
module lbm_coord_sweeper
    import lbm_coord_pkg::*;
#(
    parameter int COORD_W = 27,
    parameter int SWEEP_W = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [2:0]         address,
    input  logic               chipselect,
    input  logic               write_n,
    input  logic [31:0]        writedata,
    output logic [31:0]        readdata,
    output logic [COORD_W-1:0] coord_x,
    output logic [COORD_W-1:0] coord_y,
    output logic               coord_valid,
    input  logic               coord_ready,
    output logic               coord_last,
    output logic               busy
`ifdef LBM_COORD_IRQ_EN
    ,
    output logic               irq
`endif
);

    state_e             state_q, state_d;
    logic [COORD_W-1:0] x_max_q, x_max_d;
    logic [COORD_W-1:0] y_max_q, y_max_d;
    logic [SWEEP_W-1:0] sweeps_q, sweeps_d;
    logic [SWEEP_W-1:0] sweep_cnt_q, sweep_cnt_d;
    logic               done_q, done_d;
    logic               irq_en_rd;

    logic               wr_en;
    logic               ctrl_wr;
    logic               start_wr;
    logic               abort_wr;
    logic               cnt_clr_wr;
    logic               run;
    logic               start_go;
    logic               cnt_advance;
    logic               cnt_wrap;
    logic               cnt_last;
    logic [SWEEP_W-1:0] sweep_cnt_inc;
    logic               final_hs;
    logic               done_clr;
    logic               unused_wdata;

    // Upper writedata bits are not stored in every register.
    assign unused_wdata = ^writedata;

    assign wr_en      = chipselect && !write_n;
    assign ctrl_wr    = wr_en && (address == ADDR_CTRL);
    assign start_wr   = ctrl_wr && writedata[CTRL_START_BIT];
    assign abort_wr   = ctrl_wr && writedata[CTRL_ABORT_BIT];
    assign cnt_clr_wr = wr_en && (address == ADDR_SWEEP_CNT);
    assign run        = (state_q == RUN);

    // Abort beats start; start is only honoured from IDLE.
    assign start_go = !run && start_wr && !abort_wr;

    // A handshake coinciding with an abort write is discarded.
    assign cnt_advance = run && coord_ready && !abort_wr;

    assign sweep_cnt_inc = sweep_cnt_q + 1'b1;
    assign final_hs      = cnt_wrap && (sweeps_q != '0) && (sweep_cnt_inc == sweeps_q);
    assign done_clr      = start_go || cnt_clr_wr;

    lbm_coord_counter #(
        .COORD_W (COORD_W)
    ) u_counter (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (start_go),
        .advance (cnt_advance),
        .x_max   (x_max_q),
        .y_max   (y_max_q),
        .x       (coord_x),
        .y       (coord_y),
        .wrap    (cnt_wrap),
        .last    (cnt_last)
    );

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start_go) state_d = RUN;
            RUN: begin
                if (abort_wr)      state_d = IDLE;
                else if (final_hs) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Register file and sweep counter
    always_comb begin
        x_max_d     = x_max_q;
        y_max_d     = y_max_q;
        sweeps_d    = sweeps_q;
        sweep_cnt_d = sweep_cnt_q;
        done_d      = done_q;

        if (wr_en && !run) begin
            if (address == ADDR_X_MAX)  x_max_d  = writedata[COORD_W-1:0];
            if (address == ADDR_Y_MAX)  y_max_d  = writedata[COORD_W-1:0];
            if (address == ADDR_SWEEPS) sweeps_d = writedata[SWEEP_W-1:0];
        end

        if (start_go)      sweep_cnt_d = '0;
        else if (cnt_wrap) sweep_cnt_d = sweep_cnt_inc;

        // Completion takes priority over a same-cycle clear so it is never lost.
        if (final_hs)      done_d = 1'b1;
        else if (done_clr) done_d = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            x_max_q     <= '0;
            y_max_q     <= '0;
            sweeps_q    <= '0;
            sweep_cnt_q <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_max_q     <= x_max_d;
            y_max_q     <= y_max_d;
            sweeps_q    <= sweeps_d;
            sweep_cnt_q <= sweep_cnt_d;
            done_q      <= done_d;
        end
    end

`ifdef LBM_COORD_IRQ_EN
    logic irq_en_q, irq_en_d;
    logic irq_q, irq_d;

    always_comb begin
        irq_en_d = irq_en_q;
        if (ctrl_wr) irq_en_d = writedata[CTRL_IRQ_EN_BIT];
        // Registered copy of done && irq_en, dropped on the same edge as done.
        irq_d = done_clr ? 1'b0 : (done_q && irq_en_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            irq_en_q <= irq_en_d;
            irq_q    <= irq_d;
        end
    end

    assign irq_en_rd = irq_en_q;
    assign irq       = irq_q;
`else
    assign irq_en_rd = 1'b0;
`endif

    // Read mux
    always_comb begin
        readdata = '0;
        case (address)
            ADDR_CTRL: begin
                readdata[CTRL_BUSY_BIT]   = run;
                readdata[CTRL_DONE_BIT]   = done_q;
                readdata[CTRL_IRQ_EN_BIT] = irq_en_rd;
            end
            ADDR_X_MAX:     readdata = 32'(x_max_q);
            ADDR_Y_MAX:     readdata = 32'(y_max_q);
            ADDR_SWEEPS:    readdata = 32'(sweeps_q);
            ADDR_SWEEP_CNT: readdata = 32'(sweep_cnt_q);
            default:        readdata = '0;
        endcase
    end

    assign busy        = run;
    assign coord_valid = run;
    assign coord_last  = cnt_last && run;

endmodule
